// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared state, instruction-class and control encodings for the
//               multi-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    localparam logic [5:0] c_FN_NOP   = 6'h00;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;

    localparam logic [1:0] c_WA_RT    = 2'b00;
    localparam logic [1:0] c_WA_RD    = 2'b01;
    localparam logic [1:0] c_WA_RA    = 2'b10;

    localparam logic [1:0] c_WD_ALU   = 2'b00;
    localparam logic [1:0] c_WD_MEM   = 2'b01;
    localparam logic [1:0] c_WD_PC4   = 2'b10;

    localparam logic [1:0] c_BR_PC4   = 2'b00;
    localparam logic [1:0] c_BR_BRANCH = 2'b01;
    localparam logic [1:0] c_BR_JUMP  = 2'b10;
    localparam logic [1:0] c_BR_RS    = 2'b11;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_OR   = 3'b010;
    localparam logic [2:0] c_ALU_LUI  = 3'b011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } mc_state_e;

    typedef enum logic [3:0] {
        CLS_RALU    = 4'd0,
        CLS_IALU    = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JR      = 4'd7,
        CLS_NOP     = 4'd8,
        CLS_ILLEGAL = 4'd9
    } mc_class_e;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module      : mc_decode
// Description : Combinational op/func decode into an instruction class plus
//               the ALU controls that class uses during EXEC/MEM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_decode #(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [FUNC_W-1:0] func_i,
    output mc_pkg::mc_class_e cls_o,
    output logic [2:0]        aluctr_o,
    output logic              bctr_o,
    output logic              extctr_o
);
    import mc_pkg::*;

    always_comb begin
        cls_o    = CLS_ILLEGAL;
        aluctr_o = c_ALU_ADD;
        bctr_o   = 1'b0;
        extctr_o = 1'b0;
        case (op_i)
            OP_W'(c_OP_RTYPE): begin
                case (func_i)
                    FUNC_W'(c_FN_ADDU): cls_o = CLS_RALU;
                    FUNC_W'(c_FN_SUBU): begin
                        cls_o    = CLS_RALU;
                        aluctr_o = c_ALU_SUB;
                    end
                    FUNC_W'(c_FN_JR):   cls_o = CLS_JR;
                    FUNC_W'(c_FN_NOP):  cls_o = CLS_NOP;
                    default:            cls_o = CLS_ILLEGAL;
                endcase
            end
            OP_W'(c_OP_ORI): begin
                cls_o    = CLS_IALU;
                aluctr_o = c_ALU_OR;
                bctr_o   = 1'b1;
            end
            OP_W'(c_OP_LUI): begin
                cls_o    = CLS_IALU;
                aluctr_o = c_ALU_LUI;
                bctr_o   = 1'b1;
            end
            OP_W'(c_OP_LW), OP_W'(c_OP_SW): begin
                cls_o    = (op_i == OP_W'(c_OP_LW)) ? CLS_LOAD : CLS_STORE;
                bctr_o   = 1'b1;
                extctr_o = 1'b1;
            end
            OP_W'(c_OP_BEQ): begin
                // Branch offset is sign-extended for the target adder.
                cls_o    = CLS_BRANCH;
                aluctr_o = c_ALU_SUB;
                extctr_o = 1'b1;
            end
            OP_W'(c_OP_J):   cls_o = CLS_JUMP;
            OP_W'(c_OP_JAL): cls_o = CLS_JAL;
            default:         cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Multi-cycle MIPS controller, FETCH/DECODE/EXEC/MEM/WB sequencing
//               with imem/dmem ready stalls. MC_ILLEGAL_TRAP_EN enables the trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller #(
    parameter int OP_W     = 6,
    parameter int FUNC_W   = 6,
    parameter int ALUCTR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNC_W-1:0]   func,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                pc_we,
    output logic                ir_we,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                memwrite,
    output logic                regwrite,
    output logic [1:0]          wactr,
    output logic [1:0]          wdctr,
    output logic [1:0]          brctr,
    output logic [ALUCTR_W-1:0] aluctr,
    output logic                bctr,
    output logic                extctr,
    output logic                instr_done,
    output logic                exc_illegal
);
    import mc_pkg::*;

    mc_state_e  r_state_q;
    mc_state_e  w_state_d;
    mc_class_e  w_cls;
    logic [2:0] w_aluctr;
    logic       w_bctr;
    logic       w_extctr;

    mc_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W)
    ) u_decode (
        .op_i     (op),
        .func_i   (func),
        .cls_o    (w_cls),
        .aluctr_o (w_aluctr),
        .bctr_o   (w_bctr),
        .extctr_o (w_extctr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= FETCH;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        memwrite    = 1'b0;
        regwrite    = 1'b0;
        wactr       = c_WA_RT;
        wdctr       = c_WD_ALU;
        brctr       = c_BR_PC4;
        aluctr      = '0;
        bctr        = 1'b0;
        extctr      = 1'b0;
        instr_done  = 1'b0;
        exc_illegal = 1'b0;

        case (r_state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    brctr     = c_BR_PC4;
                    w_state_d = DECODE;
                end
            end
            DECODE: begin
                case (w_cls)
                    CLS_JUMP, CLS_JAL: begin
                        pc_we      = 1'b1;
                        brctr      = c_BR_JUMP;
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
                        if (w_cls == CLS_JAL) begin
                            regwrite = 1'b1;
                            wactr    = c_WA_RA;
                            wdctr    = c_WD_PC4;
                        end
                    end
                    CLS_JR: begin
                        pc_we      = 1'b1;
                        brctr      = c_BR_RS;
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
                    end
                    CLS_NOP: begin
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
                    end
                    CLS_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        w_state_d = TRAP;
`else
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
`endif
                    end
                    default: w_state_d = EXEC;
                endcase
            end
            EXEC: begin
                aluctr = ALUCTR_W'(w_aluctr);
                bctr   = w_bctr;
                extctr = w_extctr;
                case (w_cls)
                    CLS_BRANCH: begin
                        brctr      = c_BR_BRANCH;
                        pc_we      = zero;
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_state_d = MEM;
                    default:             w_state_d = WB;
                endcase
            end
            MEM: begin
                // Address path stays live until the access completes.
                aluctr   = ALUCTR_W'(w_aluctr);
                bctr     = w_bctr;
                extctr   = w_extctr;
                dmem_req = 1'b1;
                memwrite = (w_cls == CLS_STORE);
                if (dmem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        instr_done = 1'b1;
                        w_state_d  = FETCH;
                    end else begin
                        w_state_d = WB;
                    end
                end
            end
            WB: begin
                regwrite   = 1'b1;
                wactr      = (w_cls == CLS_RALU) ? c_WA_RD : c_WA_RT;
                wdctr      = (w_cls == CLS_LOAD) ? c_WD_MEM : c_WD_ALU;
                instr_done = 1'b1;
                w_state_d  = FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: exc_illegal = 1'b1;
`endif
            default: w_state_d = FETCH;
        endcase

        // Reset suppresses every output, including any write in flight.
        if (reset) begin
            pc_we       = 1'b0;
            ir_we       = 1'b0;
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            memwrite    = 1'b0;
            regwrite    = 1'b0;
            wactr       = c_WA_RT;
            wdctr       = c_WD_ALU;
            brctr       = c_BR_PC4;
            aluctr      = '0;
            bctr        = 1'b0;
            extctr      = 1'b0;
            instr_done  = 1'b0;
            exc_illegal = 1'b0;
        end
    end

endmodule

`default_nettype wire
